output_buffer: RTL and testbench

Transmit side of a router output port: buffers flits arriving from the crossbar and drives them onto the link toward the downstream router's input buffer, obeying that buffer's on/off backpressure. It checks packet framing on the transmit side and pulses a release signal when a packet's last flit leaves, so switch/VC allocation can free the output.

---
 rtl/noc_params.sv | 23 ++
 rtl/output_fifo.sv | 63 ++++++
 rtl/output_buffer.sv | 108 ++++++++++
 tb/tb_output_buffer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/noc_params.sv
// Shared NoC definitions: flit label encoding and the flit structure
// carried between the crossbar, the output buffers and the links.
package noc_params;

  localparam int PAYLOAD_W = 16;

  typedef enum logic [1:0] {
    HEAD     = 2'b00,
    BODY     = 2'b01,
    TAIL     = 2'b10,
    HEADTAIL = 2'b11
  } flit_label_t;

  typedef struct packed {
    flit_label_t          flit_label;
    logic [PAYLOAD_W-1:0] payload;
  } flit_t;

  function automatic logic is_tail_label(input flit_label_t label);
    return (label == TAIL) || (label == HEADTAIL);
  endfunction

endpackage

// File: rtl/output_fifo.sv
// Flit FIFO for the output port; head entry is visible combinationally and
// an occupancy counter one bit wider than the pointers separates full from empty.
module output_fifo
  import noc_params::*;
#(
  parameter int BUFFER_SIZE = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  flit_t data_i,
  input  logic  push_i,
  input  logic  pop_i,
  output flit_t data_o,
  output logic  is_empty_o,
  output logic  is_full_o
);

  localparam int PTR_W = $clog2(BUFFER_SIZE);
  localparam int CNT_W = PTR_W + 1;

  flit_t             mem [BUFFER_SIZE];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  // A push into a full FIFO is refused even if a pop frees a slot this cycle.
  assign do_push    = push_i & ~is_full_o;
  assign do_pop     = pop_i & ~is_empty_o;
  assign is_empty_o = (count == {CNT_W{1'b0}});
  assign is_full_o  = (count == CNT_W'(BUFFER_SIZE));
  assign data_o     = mem[rd_ptr];

  // Storage array; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= data_i;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= {PTR_W{1'b0}};
      wr_ptr <= {PTR_W{1'b0}};
      count  <= {CNT_W{1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/output_buffer.sv
// Router output port transmit side: buffers crossbar flits, sends them under
// downstream on/off control, checks packet framing and flags packet release.
module output_buffer
  import noc_params::*;
#(
  parameter int BUFFER_SIZE = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  flit_t data_i,
  input  logic  valid_i,
  input  logic  on_off_i,
  output flit_t data_o,
  output logic  valid_o,
  output logic  ready_o,
  output logic  is_empty_o,
  output logic  is_full_o,
  output logic  in_packet_o,
  output logic  tail_sent_o,
  output logic  error_o
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] PACKET = 1'b1;

  logic [0:0] state;
  logic [0:0] state_next;
  flit_t      head_flit;
  logic       pop;
  logic       overflow;
  logic       frame_err;
  logic       tail_hit;

  output_fifo #(
    .BUFFER_SIZE (BUFFER_SIZE)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .data_i     (data_i),
    .push_i     (valid_i),
    .pop_i      (pop),
    .data_o     (head_flit),
    .is_empty_o (is_empty_o),
    .is_full_o  (is_full_o)
  );

  assign pop      = ~is_empty_o & on_off_i;
  assign overflow = valid_i & is_full_o;
  assign ready_o  = ~is_full_o;

  // Framing check on the flit leaving the FIFO; bad flits are still sent.
  always_comb begin
    state_next = state;
    frame_err  = 1'b0;
    tail_hit   = 1'b0;
    if (pop) begin
      case (state)
        IDLE: begin
          case (head_flit.flit_label)
            HEAD:     state_next = PACKET;
            HEADTAIL: tail_hit = 1'b1;
            default:  frame_err = 1'b1;
          endcase
        end
        PACKET: begin
          case (head_flit.flit_label)
            BODY: state_next = PACKET;
            TAIL: begin
              tail_hit   = 1'b1;
              state_next = IDLE;
            end
            HEAD: frame_err = 1'b1;
            default: begin
              frame_err  = 1'b1;
              tail_hit   = 1'b1;
              state_next = IDLE;
            end
          endcase
        end
        default: state_next = IDLE;
      endcase
    end else begin
      state_next = state;
    end
  end

  // Link register and status pulses, aligned with the flit on the link.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      data_o      <= '0;
      valid_o     <= 1'b0;
      in_packet_o <= 1'b0;
      tail_sent_o <= 1'b0;
      error_o     <= 1'b0;
    end else begin
      state       <= state_next;
      valid_o     <= pop;
      in_packet_o <= (state_next == PACKET);
      tail_sent_o <= tail_hit & is_tail_label(head_flit.flit_label);
      error_o     <= frame_err | overflow;
      if (pop) begin
        data_o <= head_flit;
      end
    end
  end

endmodule

// File: tb/tb_output_buffer.sv
// Self-checking bench for output_buffer: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_output_buffer;
  import noc_params::*;

  localparam int BS = 4;

  logic  clk = 1'b0;
  logic  rst;
  flit_t data_i;
  logic  valid_i;
  logic  on_off_i;
  flit_t data_o;
  logic  valid_o, ready_o, is_empty_o, is_full_o;
  logic  in_packet_o, tail_sent_o, error_o;

  int n_vec = 0;
  int n_err = 0;

  flit_t q[$];
  flit_t exp_data;
  logic  in_pkt;

  output_buffer #(.BUFFER_SIZE(BS)) dut (
    .clk         (clk),
    .rst         (rst),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .on_off_i    (on_off_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_o     (ready_o),
    .is_empty_o  (is_empty_o),
    .is_full_o   (is_full_o),
    .in_packet_o (in_packet_o),
    .tail_sent_o (tail_sent_o),
    .error_o     (error_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic flit_t mk(input flit_label_t l, input logic [15:0] p);
    flit_t f;
    f.flit_label = l;
    f.payload    = p;
    return f;
  endfunction

  // One clock cycle: apply inputs, check status, advance model, check link outputs.
  task automatic step(input logic v, input flit_t f, input logic on);
    logic  full, do_pop, e_err, e_tail;
    flit_t p;
    valid_i  = v;
    data_i   = f;
    on_off_i = on;
    #1;
    check("is_empty", 32'(is_empty_o), 32'(q.size() == 0));
    check("is_full", 32'(is_full_o), 32'(q.size() == BS));
    check("ready", 32'(ready_o), 32'(q.size() != BS));
    full   = (q.size() == BS);
    do_pop = (q.size() != 0) && on;
    e_err  = v && full;
    e_tail = 1'b0;
    if (do_pop) begin
      p = q.pop_front();
      exp_data = p;
      case (p.flit_label)
        HEAD: begin e_err = e_err | in_pkt; in_pkt = 1'b1; end
        BODY: e_err = e_err | !in_pkt;
        TAIL: begin e_err = e_err | !in_pkt; e_tail = in_pkt; in_pkt = 1'b0; end
        default: begin e_err = e_err | in_pkt; e_tail = 1'b1; in_pkt = 1'b0; end
      endcase
    end
    if (v && !full) q.push_back(f);
    @(posedge clk);
    #1;
    check("valid_o", 32'(valid_o), 32'(do_pop));
    check("data_o", 32'(data_o), 32'(exp_data));
    check("tail_sent", 32'(tail_sent_o), 32'(e_tail));
    check("error", 32'(error_o), 32'(e_err));
    check("in_packet", 32'(in_packet_o), 32'(in_pkt));
  endtask

  task automatic idle(input int n, input logic on);
    for (int i = 0; i < n; i++) step(1'b0, mk(HEAD, 16'h0000), on);
  endtask

  task automatic check_reset_outputs();
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    check("rst_in_packet", 32'(in_packet_o), 32'd0);
    check("rst_tail", 32'(tail_sent_o), 32'd0);
    check("rst_error", 32'(error_o), 32'd0);
    check("rst_empty", 32'(is_empty_o), 32'd1);
    check("rst_full", 32'(is_full_o), 32'd0);
    check("rst_ready", 32'(ready_o), 32'd1);
  endtask

  initial begin
    rst = 1'b0; valid_i = 1'b0; on_off_i = 1'b0; data_i = mk(HEAD, 16'h0000);
    exp_data = '0; in_pkt = 1'b0;
    #12;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b1;

    // Single HEADTAIL latency and tail pulse
    step(1'b1, mk(HEADTAIL, 16'h1111), 1'b1);
    idle(3, 1'b1);

    // Back-to-back packet
    step(1'b1, mk(HEAD, 16'h2001), 1'b1);
    step(1'b1, mk(BODY, 16'h2002), 1'b1);
    step(1'b1, mk(BODY, 16'h2003), 1'b1);
    step(1'b1, mk(TAIL, 16'h2004), 1'b1);
    idle(3, 1'b1);

    // Fill while off, overflow the fifth, then drain
    for (int i = 0; i < 5; i++) step(1'b1, mk(i == 0 ? HEAD : (i == 3 ? TAIL : BODY), 16'(16'h3000 + i)), 1'b0);
    idle(6, 1'b1);

    // on/off toggling during a 6-flit stream
    for (int i = 0; i < 6; i++)
      step(1'b1, mk(i == 0 ? HEAD : (i == 5 ? TAIL : BODY), 16'(16'h4000 + i)), (i == 2 || i == 3) ? 1'b0 : 1'b1);
    idle(2, 1'b0);
    idle(5, 1'b1);

    // Framing errors: BODY in IDLE, then HEAD inside a packet
    step(1'b1, mk(BODY, 16'h5001), 1'b1);
    step(1'b1, mk(HEAD, 16'h5002), 1'b1);
    step(1'b1, mk(HEAD, 16'h5003), 1'b1);
    step(1'b1, mk(HEADTAIL, 16'h5004), 1'b1);
    step(1'b1, mk(TAIL, 16'h5005), 1'b1);
    idle(3, 1'b1);

    // Asynchronous reset with three flits buffered inside a packet
    step(1'b1, mk(HEAD, 16'h6001), 1'b1);
    idle(1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, mk(BODY, 16'(16'h6002 + i)), 1'b0);
    check("pre_rst_in_packet", 32'(in_packet_o), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_reset_outputs();
    q.delete(); in_pkt = 1'b0; exp_data = '0;
    @(negedge clk);
    rst = 1'b1;
    idle(4, 1'b1);

    // Random traffic
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 3) != 0,
           mk(flit_label_t'(2'($urandom_range(0, 3))), 16'($urandom)),
           $urandom_range(0, 2) != 0);
    idle(BS + 2, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
